// File: rtl/onewire_tx_multi.sv
// onewire_tx_multi: multi-byte 1-Wire write master.
// Optionally issues a reset/presence sequence, then sends i_tx_len bytes
// (byte 0 first, each byte LSB first) using standard write slots. All phases
// are timed by a single shared down-counter in units of US_CYC clock cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   i_tx_data    payload, byte 0 in bits [7:0]
//   i_tx_len     byte count (clamped to MAX_BYTES)
//   i_tx_rst_en  precede payload with reset/presence sequence
//   i_tx_start   level request, accepted only in IDLE
//   bus          open-drain line: driven 0 or released
//   o_tx_busy    transaction in progress
//   o_tx_done    one-cycle completion pulse
//   o_tx_err     no presence detected (held until next accepted start)
//
// Build option: define ONEWIRE_PRESENCE_CHK_EN to sample bus at the end of
// the presence window and abort the transaction when no device answers.
// Without it o_tx_err is constant 0.
module onewire_tx_multi #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned MAX_BYTES   = 7,
  parameter int unsigned RST_LOW_US  = 480,
  parameter int unsigned PRES_SMP_US = 70,
  parameter int unsigned RST_REC_US  = 410,
  parameter int unsigned SLOT_US     = 60,
  parameter int unsigned WR1_LOW_US  = 6,
  parameter int unsigned WR0_LOW_US  = 60,
  parameter int unsigned REC_US      = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [8*MAX_BYTES-1:0]           i_tx_data,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   i_tx_len,
  input  logic                             i_tx_rst_en,
  input  logic                             i_tx_start,
  inout  wire                              bus,
  output logic                             o_tx_busy,
  output logic                             o_tx_done,
  output logic                             o_tx_err
);

  localparam int unsigned LEN_W  = $clog2(MAX_BYTES+1);
  localparam int unsigned BITS_W = LEN_W + 3;
  localparam int unsigned DW     = 8*MAX_BYTES;
  localparam int unsigned US_CYC = CLK_FREQ_HZ / 1000000;

  localparam int unsigned T_RST_LOW = RST_LOW_US  * US_CYC;
  localparam int unsigned T_PRES    = PRES_SMP_US * US_CYC;
  localparam int unsigned T_RST_REC = RST_REC_US  * US_CYC;
  localparam int unsigned T_WR1     = WR1_LOW_US  * US_CYC;
  localparam int unsigned T_WR0     = WR0_LOW_US  * US_CYC;
  localparam int unsigned T_REL1    = (SLOT_US - WR1_LOW_US) * US_CYC;
  localparam int unsigned T_REL0    = (SLOT_US - WR0_LOW_US) * US_CYC;
  localparam int unsigned T_REC     = REC_US * US_CYC;

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, RST_REC, BIT_LOW, BIT_REL, BIT_REC, DONE
  } state_t;

  state_t              state, state_n;
  logic [31:0]         cnt, cnt_n;
  logic [DW-1:0]       shreg;
  logic [BITS_W-1:0]   bits_left;
  logic [LEN_W-1:0]    len_c;
  logic                load, shift;
  logic                drive_low;
  logic [31:0]         rel_cyc;

  // Counter preload for a bit's low phase (phase length minus one).
  function automatic logic [31:0] low_m1(input logic b);
    return b ? 32'(T_WR1 - 1) : 32'(T_WR0 - 1);
  endfunction

  assign len_c   = (i_tx_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_tx_len;
  assign rel_cyc = shreg[0] ? 32'(T_REL1) : 32'(T_REL0);

`ifdef ONEWIRE_PRESENCE_CHK_EN
  logic set_err, clr_err, err;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - 32'd1 : '0;
    load    = 1'b0;
    shift   = 1'b0;
`ifdef ONEWIRE_PRESENCE_CHK_EN
    set_err = 1'b0;
    clr_err = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (i_tx_start) begin
          load = 1'b1;
`ifdef ONEWIRE_PRESENCE_CHK_EN
          clr_err = 1'b1;
`endif
          if (i_tx_rst_en) begin
            state_n = RST_LOW;
            cnt_n   = 32'(T_RST_LOW - 1);
          end else if (len_c != '0) begin
            state_n = BIT_LOW;
            cnt_n   = low_m1(i_tx_data[0]);
          end else begin
            state_n = DONE;
          end
        end
      end
      RST_LOW: begin
        if (cnt == '0) begin
          state_n = RST_WAIT;
          cnt_n   = 32'(T_PRES - 1);
        end
      end
      RST_WAIT: begin
        if (cnt == '0) begin
          state_n = RST_REC;
          cnt_n   = 32'(T_RST_REC - 1);
`ifdef ONEWIRE_PRESENCE_CHK_EN
          // Line still high at the end of the window: nobody answered.
          if (bus) begin
            set_err = 1'b1;
            state_n = DONE;
            cnt_n   = '0;
          end
`endif
        end
      end
      RST_REC: begin
        if (cnt == '0) begin
          if (bits_left != '0) begin
            state_n = BIT_LOW;
            cnt_n   = low_m1(shreg[0]);
          end else begin
            state_n = DONE;
          end
        end
      end
      BIT_LOW: begin
        if (cnt == '0) begin
          // A zero bit's low phase already fills the slot, so the release
          // phase is skipped entirely when its length is zero.
          if (rel_cyc != '0) begin
            state_n = BIT_REL;
            cnt_n   = rel_cyc - 32'd1;
          end else begin
            state_n = BIT_REC;
            cnt_n   = 32'(T_REC - 1);
          end
        end
      end
      BIT_REL: begin
        if (cnt == '0) begin
          state_n = BIT_REC;
          cnt_n   = 32'(T_REC - 1);
        end
      end
      BIT_REC: begin
        if (cnt == '0) begin
          shift = 1'b1;
          if (bits_left == BITS_W'(1)) begin
            state_n = DONE;
          end else begin
            state_n = BIT_LOW;
            // shreg shifts on this same edge, so the next bit is shreg[1].
            cnt_n   = low_m1(shreg[1]);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      bits_left <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        shreg     <= i_tx_data;
        bits_left <= {len_c, 3'b000};
      end else if (shift) begin
        shreg     <= shreg >> 1;
        bits_left <= bits_left - BITS_W'(1);
      end
    end
  end

`ifdef ONEWIRE_PRESENCE_CHK_EN
  always_ff @(posedge clk) begin
    if (reset)        err <= 1'b0;
    else if (clr_err) err <= 1'b0;
    else if (set_err) err <= 1'b1;
  end
  assign o_tx_err = err;
`else
  assign o_tx_err = 1'b0;
`endif

  assign drive_low = (state == RST_LOW) || (state == BIT_LOW);
  assign bus       = drive_low ? 1'b0 : 1'bz;
  assign o_tx_busy = (state != IDLE) && (state != DONE);
  assign o_tx_done = (state == DONE);

endmodule
